seq_signed_divider: RTL and testbench
=====================================

# seq_signed_divider

Multi-cycle signed integer divider for the ALU datapath: the inverse of the adder/multiplier path, computing quotient and remainder of two's-complement operands by restoring shift-subtract over BITS iterations. Sits beside the combinational adder in the ALU. Driven by the control unit with a start/done handshake. Results feed the LO (quotient) and HI (remainder) registers.

## Interface
- BITS, 32, operand/result width (≥4)
- clk  in  1  clock, all state changes on rising edge
- clr  in  1  reset: synchronous, active-low
- start  in  1  request; sampled only in IDLE
- dividend  in  BITS  signed numerator, captured on accepted start
- divisor  in  BITS  signed denominator, captured on accepted start
- busy  out  1  high from the cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, results valid
- quotient  out  BITS  signed quotient, held until next accepted start
- remainder  out  BITS  signed remainder, held until next accepted start
- div_by_zero  out  1  set with done when divisor was 0, held with results

## Operation
- States: IDLE, DIVIDE, FIXUP, DONE.
- IDLE: start=1 captures |dividend| into quotient shift reg, clears partial remainder (BITS+1 bits), stores |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend), zero flag = (divisor==0), loads iteration counter = BITS-1 → DIVIDE.
- Magnitude of most-negative value = 2^(BITS-1), held as unsigned BITS-bit. No overflow.
- DIVIDE, per cycle: shifted = {rem, q[BITS-1]}; diff = shifted − {0,|divisor|} in BITS+1 bits. If diff ≥ 0: rem=diff, q={q[BITS-2:0],1}. Else: rem=shifted, q={q[BITS-2:0],0}. Counter decrements. At counter 0 → FIXUP.
- FIXUP: quotient = sign_q ? −q : q; remainder = sign_r ? −rem : rem (truncating division; remainder takes dividend's sign). Divisor zero overrides: quotient = all ones, remainder = original dividend, div_by_zero=1. → DONE.
- DONE: done=1 for one cycle → IDLE.
- Overflow case (−2^(BITS-1) / −1): quotient = −2^(BITS-1) (wraps), remainder 0, no flag.
- start while busy: ignored, no queueing. start held high through DONE: a new operation is accepted only in the following IDLE cycle.
- Operands are not sampled after the start cycle; changes during busy have no effect.

## Timing
- Reset (clr=0 at an edge): state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Reset mid-operation aborts immediately. No done pulse; outputs zeroed as above.
- Fixed latency, independent of operand values, including divide-by-zero. Start accepted at edge E0 (state becomes DIVIDE). BITS DIVIDE cycles. FIXUP one cycle. done high during the cycle after edge E0+BITS+1. For BITS=32, done is visible 34 cycles after the start cycle.
- busy=1 in DIVIDE, FIXUP, DONE. Minimum start-to-start spacing: BITS+3 cycles.
- quotient/remainder/div_by_zero change only on the FIXUP→DONE edge and on reset.

## Structure
- Shared ALU package: state encoding (IDLE/DIVIDE/FIXUP/DONE), default BITS, divide-by-zero quotient constant (all ones).
- One sub-module: div_step. Combinational single iteration, shifted remainder and divisor in, next remainder plus quotient bit out. Its subtractor is BITS+1 wide.
- Negation in FIXUP: ~x+1 on BITS bits.

## Test plan
- 100 / 7 → quotient 14, remainder 2, div_by_zero 0. done exactly 34 cycles after start cycle (BITS=32). busy high 33 cycles.
- −100 / 7 → quotient −14 (0xFFFFFFF2), remainder −2. 100 / −7 → −14, 2. −100 / −7 → 14, −2.
- 7 / 0 → quotient 0xFFFFFFFF, remainder 7, div_by_zero 1, same 34-cycle latency.
- 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. 0x80000000 / 1 → quotient 0x80000000, remainder 0.
- start pulsed and operands changed at cycle 10 of a busy operation → ignored, first result unaffected. Back-to-back start held high → second operation accepted the cycle after done.
- clr low at cycle 15 of a divide → next cycle IDLE, all outputs 0, no done. Fresh 9 / 3 afterwards → quotient 3, remainder 0.

Source files
------------

// File: rtl/seq_signed_divider_pkg.sv
// Shared ALU divider definitions: FSM state encoding, default width and
// the quotient fill pattern used when the divisor is zero.
package seq_signed_divider_pkg;

  localparam int DIV_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIXUP  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Divide-by-zero quotient is every bit set to this value (all ones).
  localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/done request bus between the ALU control unit (master) and the
// sequential divider (slave).
interface seq_signed_divider_if
  import seq_signed_divider_pkg::*;
#(
  parameter int BITS = DIV_BITS
);
  logic            start;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
  logic            busy;
  logic            done;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_signed_divider_div_step.sv
// One restoring shift-subtract iteration on magnitudes; purely combinational.
// The BITS+1-bit difference is exact because shifted < 2*divisor <= 2^BITS.
module div_step
  import seq_signed_divider_pkg::*;
#(
  parameter int BITS = DIV_BITS
) (
  input  logic [BITS:0]   shifted,
  input  logic [BITS-1:0] divisor,
  output logic [BITS-1:0] rem_next,
  output logic            qbit
);
  logic [BITS:0] diff;

  assign diff     = shifted - {1'b0, divisor};
  assign qbit     = ~diff[BITS];
  // A kept remainder is always below the divisor, so BITS bits hold it.
  assign rem_next = qbit ? diff[BITS-1:0] : shifted[BITS-1:0];
endmodule

// File: rtl/seq_signed_divider.sv
// Signed truncating divider, BITS+2 cycles from accepted start to done pulse.
// Start is only sampled in IDLE; requests while busy are dropped, not queued.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int BITS = DIV_BITS
) (
  input  logic                 clk,
  input  logic                 clr,
  seq_signed_divider_if.slave  bus
);
  localparam int CW = $clog2(BITS);
  localparam logic [BITS-1:0] ONE = BITS'(1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] q_sh, rem, dvs_mag, dvd_orig;
  logic            sign_q, sign_r, zero;
  logic [BITS-1:0] quo_r, rem_r;
  logic            dbz_r;

  logic [BITS-1:0] dvd_mag_in, dvs_mag_in, step_rem;
  logic            step_qbit;

  // Most-negative operand maps to 2^(BITS-1), which is exact as unsigned.
  assign dvd_mag_in = bus.dividend[BITS-1] ? (~bus.dividend + ONE) : bus.dividend;
  assign dvs_mag_in = bus.divisor[BITS-1]  ? (~bus.divisor + ONE)  : bus.divisor;

  div_step #(.BITS(BITS)) u_step (
    .shifted  ({rem, q_sh[BITS-1]}),
    .divisor  (dvs_mag),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (!clr) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_DIVIDE;
      ST_DIVIDE: if (cnt == '0) state_nxt = ST_FIXUP;
      ST_FIXUP:  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt      <= '0;
      q_sh     <= '0;
      rem      <= '0;
      dvs_mag  <= '0;
      dvd_orig <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero     <= 1'b0;
      quo_r    <= '0;
      rem_r    <= '0;
      dbz_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            q_sh     <= dvd_mag_in;
            rem      <= '0;
            dvs_mag  <= dvs_mag_in;
            dvd_orig <= bus.dividend;
            sign_q   <= bus.dividend[BITS-1] ^ bus.divisor[BITS-1];
            sign_r   <= bus.dividend[BITS-1];
            zero     <= (bus.divisor == '0);
            cnt      <= CW'(BITS - 1);
          end
        end
        ST_DIVIDE: begin
          rem  <= step_rem;
          q_sh <= {q_sh[BITS-2:0], step_qbit};
          cnt  <= cnt - CW'(1);
        end
        ST_FIXUP: begin
          quo_r <= zero ? {BITS{DBZ_Q_FILL}} : (sign_q ? (~q_sh + ONE) : q_sh);
          rem_r <= zero ? dvd_orig : (sign_r ? (~rem + ONE) : rem);
          dbz_r <= zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = (state == ST_DONE);
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Randomised and directed checks of seq_signed_divider against plain
// signed 64-bit arithmetic; inputs change and outputs are read on negedge.
module tb_seq_signed_divider;
  localparam int BITS = 32;
  localparam int LAT  = BITS + 2;

  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_signed_divider_if #(.BITS(BITS)) dif ();

  seq_signed_divider #(.BITS(BITS)) dut (
    .clk (clk),
    .clr (clr),
    .bus (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'($urandom_range(0, 255));
      5:       v = -32'($urandom_range(1, 255));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Called on a negedge of an IDLE cycle, which becomes the start cycle.
  // With hold=1 start stays high and the task returns on the done cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input bit poke10, input bit hold);
    logic [31:0] eq, er;
    logic        ez;
    int          lat, bsy;
    bit          busy_at_done;
    ref_div(a, b, eq, er, ez);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    lat = 0;
    bsy = 0;
    busy_at_done = 1'b0;
    for (int c = 1; c <= 3 * LAT; c++) begin
      @(negedge clk);
      if (!hold) dif.start = poke10 && (c == 10);
      if (scramble) begin
        dif.dividend = $urandom;
        dif.divisor  = $urandom;
      end
      if (dif.done) begin
        lat = c;
        busy_at_done = dif.busy;
        break;
      end
      if (dif.busy) bsy++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_busy_cycles"}, 64'(bsy), 64'(LAT - 1));
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd1);
    check({tag, "_quotient"}, 64'(dif.quotient), 64'(eq));
    check({tag, "_remainder"}, 64'(dif.remainder), 64'(er));
    check({tag, "_dbz"}, 64'(dif.div_by_zero), 64'(ez));
    if (!hold) begin
      dif.start = 1'b0;
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(dif.done), 64'd0);
      check({tag, "_idle"}, 64'(dif.busy), 64'd0);
      check({tag, "_held_q"}, 64'(dif.quotient), 64'(eq));
    end
  endtask

  initial begin
    bit seen_done;
    clr          = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(dif.busy), 64'd0);
    check("rst_done", 64'(dif.done), 64'd0);
    check("rst_quotient", 64'(dif.quotient), 64'd0);
    check("rst_remainder", 64'(dif.remainder), 64'd0);
    check("rst_dbz", 64'(dif.div_by_zero), 64'd0);
    clr = 1'b1;
    @(negedge clk);

    run_op("pos_pos", 32'd100, 32'd7, 0, 0, 0);
    run_op("neg_pos", -32'sd100, 32'd7, 0, 0, 0);
    check("neg_pos_q_lit", 64'(dif.quotient), 64'h0000_0000_FFFF_FFF2);
    run_op("pos_neg", 32'd100, -32'sd7, 0, 0, 0);
    run_op("neg_neg", -32'sd100, -32'sd7, 0, 0, 0);
    run_op("div_zero", 32'd7, 32'd0, 0, 0, 0);
    run_op("min_by_m1", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    check("min_by_m1_q_lit", 64'(dif.quotient), 64'h0000_0000_8000_0000);
    run_op("min_by_1", 32'h8000_0000, 32'd1, 0, 0, 0);
    run_op("ignored_start", 32'd12345, -32'sd77, 1, 1, 0);

    // Start held through DONE: the next request is taken in the IDLE cycle after.
    run_op("b2b_first", 32'd1000, 32'd33, 0, 0, 1);
    dif.dividend = -32'sd5000;
    dif.divisor  = 32'd17;
    @(negedge clk);
    check("b2b_idle_gap", 64'(dif.busy), 64'd0);
    run_op("b2b_second", -32'sd5000, 32'd17, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      run_op("rand", pick_operand(), pick_operand(), ($urandom_range(0, 1) == 1), 0, 0);
    end

    run_op("pre_abort", 32'd100, 32'd7, 0, 0, 0);
    dif.start    = 1'b1;
    dif.dividend = 32'd1000;
    dif.divisor  = 32'd3;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    clr = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(dif.busy), 64'd0);
    check("abort_done", 64'(dif.done), 64'd0);
    check("abort_quotient", 64'(dif.quotient), 64'd0);
    check("abort_remainder", 64'(dif.remainder), 64'd0);
    check("abort_dbz", 64'(dif.div_by_zero), 64'd0);
    clr = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < LAT + 6; c++) begin
      @(negedge clk);
      if (dif.done || dif.busy) seen_done = 1'b1;
    end
    check("abort_no_activity", 64'(seen_done), 64'd0);
    run_op("after_abort", 32'd9, 32'd3, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
